alu_mdu_control: RTL and testbench

Parametrised successor to the single-cycle ALU decoder. Decodes {funct7 bits, ALU_Op, funct3} into the ALU operation code, covering the full RV32I ALU set. Adds RV32M support: recognises MUL/DIV/REM instructions and sequences the iterative multiply/divide unit (MDU) through a cycle-counting FSM. Stalls the single-cycle core (PC hold, register-file write inhibit) until the MDU result is ready. Sits between the main control unit, the ALU and the MDU.

---
 rtl/alu_mdu_control.sv | 186 ++++++++++++++++++
 tb/tb_alu_mdu_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_control.sv
// ALU decoder for RV32I/M with a cycle-counting sequencer for the iterative MDU.
// Optional illegal_o output: define ALU_CTRL_ILLEGAL_EN.
module alu_mdu_control #(
  parameter int ALU_OP_WIDTH    = 3,
  parameter int OPERATION_WIDTH = 4,
  parameter int MUL_CYCLES      = 4,
  parameter int DIV_CYCLES      = 32,
  parameter int CNT_WIDTH       = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       funct7_5_i,
  input  logic                       funct7_0_i,
  input  logic [ALU_OP_WIDTH-1:0]    ALU_Op_i,
  input  logic [2:0]                 funct3_i,
  input  logic                       div_by_zero_i,
  input  logic                       flush_i,
  output logic [OPERATION_WIDTH-1:0] ALU_Operation_o,
  output logic                       mdu_start_o,
  output logic [2:0]                 mdu_op_o,
  output logic                       stall_o,
  output logic                       mdu_sel_o,
  output logic                       busy_o
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic                       illegal_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [ALU_OP_WIDTH-1:0] CL_R   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] CL_I   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] CL_LUI = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] CL_BR  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] CL_MEM = ALU_OP_WIDTH'(4);

  localparam logic [OPERATION_WIDTH-1:0] OP_ADD  = OPERATION_WIDTH'(4'b0000);
  localparam logic [OPERATION_WIDTH-1:0] OP_SUB  = OPERATION_WIDTH'(4'b0001);
  localparam logic [OPERATION_WIDTH-1:0] OP_AND  = OPERATION_WIDTH'(4'b0010);
  localparam logic [OPERATION_WIDTH-1:0] OP_OR   = OPERATION_WIDTH'(4'b0011);
  localparam logic [OPERATION_WIDTH-1:0] OP_XOR  = OPERATION_WIDTH'(4'b0100);
  localparam logic [OPERATION_WIDTH-1:0] OP_SLL  = OPERATION_WIDTH'(4'b0101);
  localparam logic [OPERATION_WIDTH-1:0] OP_SRL  = OPERATION_WIDTH'(4'b0110);
  localparam logic [OPERATION_WIDTH-1:0] OP_SRA  = OPERATION_WIDTH'(4'b0111);
  localparam logic [OPERATION_WIDTH-1:0] OP_SLT  = OPERATION_WIDTH'(4'b1000);
  localparam logic [OPERATION_WIDTH-1:0] OP_SLTU = OPERATION_WIDTH'(4'b1001);
  localparam logic [OPERATION_WIDTH-1:0] OP_LUI  = OPERATION_WIDTH'(4'b1010);

  localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic [2:0]             op_q;
  logic [2:0]             op_nxt;
  logic [OPERATION_WIDTH-1:0] base_op;
  logic [OPERATION_WIDTH-1:0] alu_op;
  logic                   illegal;
  logic                   m_op;
  logic                   is_div;
  logic                   dz_div;
  logic                   start;
  logic                   stall;
  logic                   sel;

  assign m_op   = (ALU_Op_i == CL_R) && funct7_0_i;
  assign is_div = funct3_i[2];
  assign dz_div = is_div && div_by_zero_i;

  always_comb begin
    base_op = OP_ADD;
    unique case (funct3_i)
      3'b000: base_op = OP_ADD;
      3'b001: base_op = OP_SLL;
      3'b010: base_op = OP_SLT;
      3'b011: base_op = OP_SLTU;
      3'b100: base_op = OP_XOR;
      3'b101: base_op = OP_SRL;
      3'b110: base_op = OP_OR;
      3'b111: base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  end

  always_comb begin
    alu_op  = OP_ADD;
    illegal = 1'b0;
    if (!m_op) begin
      case (ALU_Op_i)
        CL_R: begin
          if (!funct7_5_i) begin
            alu_op = base_op;
          end else if (funct3_i == 3'b000) begin
            alu_op = OP_SUB;
          end else if (funct3_i == 3'b101) begin
            alu_op = OP_SRA;
          end else begin
            illegal = 1'b1;
          end
        end
        CL_I: begin
          if (funct3_i == 3'b101 && funct7_5_i) alu_op = OP_SRA;
          else                                  alu_op = base_op;
        end
        CL_LUI:  alu_op = OP_LUI;
        CL_BR:   alu_op = OP_SUB;
        CL_MEM:  alu_op = OP_ADD;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign ALU_Operation_o = alu_op;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    start     = 1'b0;
    stall     = 1'b0;
    sel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_op && !flush_i) begin
          stall  = 1'b1;
          op_nxt = funct3_i;
          if (dz_div) begin
            state_nxt = DONE;
          end else begin
            start     = 1'b1;
            cnt_nxt   = is_div ? DIV_LOAD : MUL_LOAD;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE: begin
        sel       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // flush wins over every transition, including a fresh launch
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'b000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  assign mdu_start_o = start && !reset;
  assign stall_o     = stall && !reset;
  assign mdu_sel_o   = sel && !reset;
  assign busy_o      = (state != IDLE) && !reset;
  assign mdu_op_o    = op_q;

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal_o = illegal && (state == IDLE) && !reset;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode table plus MDU sequencing cases.
module tb_alu_mdu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       funct7_5_i;
  logic       funct7_0_i;
  logic [2:0] ALU_Op_i;
  logic [2:0] funct3_i;
  logic       div_by_zero_i;
  logic       flush_i;
  logic [3:0] ALU_Operation_o;
  logic       mdu_start_o;
  logic [2:0] mdu_op_o;
  logic       stall_o;
  logic       mdu_sel_o;
  logic       busy_o;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       illegal_o;
`endif

  int total = 0;
  int passed = 0;
  int s1, s2, d1, d2;
  bit sel_seen;

  typedef struct {
    logic [2:0] cls;
    logic       f75;
    logic [2:0] f3;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [19];

  alu_mdu_control dut (
    .clk             (clk),
    .reset           (reset),
    .funct7_5_i      (funct7_5_i),
    .funct7_0_i      (funct7_0_i),
    .ALU_Op_i        (ALU_Op_i),
    .funct3_i        (funct3_i),
    .div_by_zero_i   (div_by_zero_i),
    .flush_i         (flush_i),
    .ALU_Operation_o (ALU_Operation_o),
    .mdu_start_o     (mdu_start_o),
    .mdu_op_o        (mdu_op_o),
    .stall_o         (stall_o),
    .mdu_sel_o       (mdu_sel_o),
    .busy_o          (busy_o)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal_o       (illegal_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [2:0] cls, input logic f75,
                       input logic f70, input logic [2:0] f3);
    ALU_Op_i   = cls;
    funct7_5_i = f75;
    funct7_0_i = f70;
    funct3_i   = f3;
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 3'b000, 4'b0000};
    vecs[1]  = '{3'b000, 1'b1, 3'b000, 4'b0001};
    vecs[2]  = '{3'b000, 1'b0, 3'b001, 4'b0101};
    vecs[3]  = '{3'b000, 1'b0, 3'b010, 4'b1000};
    vecs[4]  = '{3'b000, 1'b0, 3'b011, 4'b1001};
    vecs[5]  = '{3'b000, 1'b0, 3'b100, 4'b0100};
    vecs[6]  = '{3'b000, 1'b0, 3'b101, 4'b0110};
    vecs[7]  = '{3'b000, 1'b1, 3'b101, 4'b0111};
    vecs[8]  = '{3'b000, 1'b0, 3'b110, 4'b0011};
    vecs[9]  = '{3'b000, 1'b0, 3'b111, 4'b0010};
    vecs[10] = '{3'b000, 1'b1, 3'b001, 4'b0000};
    vecs[11] = '{3'b001, 1'b1, 3'b101, 4'b0111};
    vecs[12] = '{3'b001, 1'b1, 3'b000, 4'b0000};
    vecs[13] = '{3'b001, 1'b0, 3'b010, 4'b1000};
    vecs[14] = '{3'b001, 1'b0, 3'b101, 4'b0110};
    vecs[15] = '{3'b010, 1'b0, 3'b000, 4'b1010};
    vecs[16] = '{3'b011, 1'b0, 3'b001, 4'b0001};
    vecs[17] = '{3'b100, 1'b0, 3'b010, 4'b0000};
    vecs[18] = '{3'b110, 1'b0, 3'b000, 4'b0000};

    reset = 1'b1;
    div_by_zero_i = 1'b0;
    flush_i = 1'b0;
    apply(3'b000, 1'b0, 1'b0, 3'b000);
    tick();
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_op", {29'd0, mdu_op_o}, 32'd0);
    reset = 1'b0;
    tick();

    // reset asserted while BUSY with cnt == 2
    apply(3'b000, 1'b0, 1'b1, 3'b000);
    check("mr_start", {31'd0, mdu_start_o}, 32'd1);
    tick();
    tick();
    check("mr_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    #1;
    check("mr_start0", {31'd0, mdu_start_o}, 32'd0);
    check("mr_stall0", {31'd0, stall_o}, 32'd0);
    check("mr_sel0", {31'd0, mdu_sel_o}, 32'd0);
    check("mr_busy0", {31'd0, busy_o}, 32'd0);
    check("mr_op0", {29'd0, mdu_op_o}, 32'd0);
    apply(3'b000, 1'b1, 1'b0, 3'b000);
    reset = 1'b0;
    #1;
    check("post_alu", {28'd0, ALU_Operation_o}, 32'h1);
    check("post_stall", {31'd0, stall_o}, 32'd0);
    tick();

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].cls, vecs[i].f75, 1'b0, vecs[i].f3);
      check($sformatf("dec%0d", i), {28'd0, ALU_Operation_o},
            {28'd0, vecs[i].exp});
      check($sformatf("dec%0d_stall", i), {31'd0, stall_o}, 32'd0);
      tick();
    end

    // MUL: LAT=4, occupancy 6
    apply(3'b000, 1'b0, 1'b1, 3'b000);
    check("mul_alu", {28'd0, ALU_Operation_o}, 32'h0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("mul_start_c%0d", c), {31'd0, mdu_start_o},
            {31'd0, c == 0});
      check($sformatf("mul_stall_c%0d", c), {31'd0, stall_o},
            {31'd0, c <= 4});
      check($sformatf("mul_sel_c%0d", c), {31'd0, mdu_sel_o},
            {31'd0, c == 5});
      check($sformatf("mul_busy_c%0d", c), {31'd0, busy_o},
            {31'd0, c >= 1});
      tick();
    end
    apply(3'b000, 1'b0, 1'b0, 3'b000);
    check("mul_c6_busy", {31'd0, busy_o}, 32'd0);
    check("mul_c6_start", {31'd0, mdu_start_o}, 32'd0);
    tick();

    // DIVU by zero
    div_by_zero_i = 1'b1;
    apply(3'b000, 1'b0, 1'b1, 3'b101);
    check("dz_start", {31'd0, mdu_start_o}, 32'd0);
    check("dz_stall0", {31'd0, stall_o}, 32'd1);
    tick();
    check("dz_sel1", {31'd0, mdu_sel_o}, 32'd1);
    check("dz_stall1", {31'd0, stall_o}, 32'd0);
    check("dz_op", {29'd0, mdu_op_o}, 32'h5);
    div_by_zero_i = 1'b0;
    apply(3'b000, 1'b0, 1'b0, 3'b000);
    tick();
    check("dz_idle", {31'd0, busy_o}, 32'd0);

    // flush in BUSY cycle 10 of a DIV
    sel_seen = 1'b0;
    apply(3'b000, 1'b0, 1'b1, 3'b100);
    check("fl_start", {31'd0, mdu_start_o}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      sel_seen |= mdu_sel_o;
    end
    check("fl_busy10", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    apply(3'b000, 1'b0, 1'b0, 3'b000);
    check("fl_busy", {31'd0, busy_o}, 32'd0);
    check("fl_stall", {31'd0, stall_o}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      sel_seen |= mdu_sel_o;
      tick();
    end
    check("fl_no_sel", {31'd0, sel_seen}, 32'd0);

    // back-to-back REM then MULHU
    s1 = -1; s2 = -1; d1 = -1; d2 = -1;
    apply(3'b000, 1'b0, 1'b1, 3'b110);
    for (int c = 0; c < 100 && d2 < 0; c++) begin
      if (mdu_start_o) begin
        if (s1 < 0) s1 = c;
        else if (s2 < 0) s2 = c;
      end
      if (mdu_sel_o) begin
        if (d1 < 0) begin
          d1 = c;
          apply(3'b000, 1'b0, 1'b1, 3'b011);
        end else begin
          d2 = c;
          apply(3'b000, 1'b0, 1'b0, 3'b000);
        end
      end
      tick();
    end
    check("b2b_s1", s1, 32'd0);
    check("b2b_d1", d1, 32'd33);
    check("b2b_s2", s2, 32'd34);
    check("b2b_total", d2 + 1, 32'd40);
    check("b2b_op", {29'd0, mdu_op_o}, 32'h3);
    check("b2b_idle", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
